seg7_scan_driver: RTL and testbench

Downstream consumer of the datapath's 16-bit debug result word (the value driven to the Basys board display). Captures the word into a shadow register on a load strobe and time-multiplexes it as four hex digits onto the board's common-anode 7-segment display. Supports optional leading-zero blanking and per-digit decimal points. All display outputs are registered.

---
 rtl/seg7_scan_driver.sv | 128 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner: shadows a 16-bit word on load and
// multiplexes it as hex digits with optional leading-zero blanking and decimal points.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             new_frame_q, new_frame_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_tick_q, frame_tick_d;

  logic             wrap;
  logic [3:0]       nibble;
  logic [6:0]       hex_seg;
  logic             blanked;

  always_comb begin
    shadow_d = load ? value : shadow_q;
    wrap     = (cnt_q == CNT_LAST);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    sel_d    = wrap ? sel_q + 2'd1 : sel_q;
    // Remember that digit 3's slot just ended so the tick lines up with digit 0 on the outputs.
    new_frame_d  = wrap && (sel_q == 2'd3);
    frame_tick_d = new_frame_q;
  end

  always_comb begin
    nibble = 4'h0;
    case (sel_q)
      2'd0: nibble = shadow_q[3:0];
      2'd1: nibble = shadow_q[7:4];
      2'd2: nibble = shadow_q[11:8];
      2'd3: nibble = shadow_q[15:12];
      default: nibble = 4'h0;
    endcase
  end

  always_comb begin
    hex_seg = 7'b1111111;
    case (nibble)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      4'hF: hex_seg = 7'b0001110;
      default: hex_seg = 7'b1111111;
    endcase
  end

  // A digit is blank only when it and every more significant nibble are zero; digit 0 always shows.
  always_comb begin
    blanked = 1'b0;
    case (sel_q)
      2'd1: blanked = blank_lz && (shadow_q[15:4] == 12'h000);
      2'd2: blanked = blank_lz && (shadow_q[15:8] == 8'h00);
      2'd3: blanked = blank_lz && (shadow_q[15:12] == 4'h0);
      default: blanked = 1'b0;
    endcase
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!blanked) begin
      an_d[sel_q] = 1'b0;
      seg_d       = hex_seg;
      dp_d        = ~dp_en[sel_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= '0;
      cnt_q        <= '0;
      sel_q        <= '0;
      new_frame_q  <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      new_frame_q  <= new_frame_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a short refresh period: fixed digit vectors,
// random traffic against a slot-arithmetic model, async reset and frame timing.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  // Model state: edges since reset release and the word the display should hold.
  int          m_n;
  logic [15:0] m_shadow;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [3:0]  dpe;
    int          digit;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
  } vec_t;

  vec_t vecs [12];

  seg7_scan_driver #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .dp_en(dp_en), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Digit shown after edge number n (n counts from 1 after reset release).
  function automatic int digit_of(input int n);
    return ((n - 1) / DIV) % 4;
  endfunction

  function automatic logic [11:0] model_out(input int d, input logic [15:0] sh,
                                            input logic blz, input logic [3:0] dpe);
    logic [3:0] a;
    logic [3:0] nib;
    if (d != 0 && blz && ((sh >> (4 * d)) == 16'h0000)) return {4'hF, 7'h7F, 1'b1};
    a = 4'hF;
    a[d] = 1'b0;
    nib = 4'((sh >> (4 * d)) & 16'h000F);
    return {a, hex_tbl[nib], ~dpe[d]};
  endfunction

  // One clock: predict from pre-edge inputs, advance, then compare #1 after the edge.
  task automatic cycle();
    logic [11:0] e;
    logic        e_ft;
    int          n;
    n    = m_n + 1;
    e    = model_out(digit_of(n), m_shadow, blank_lz, dp_en);
    e_ft = (n > 1) && ((n - 1) % FRAME == 0);
    @(posedge clk);
    #1;
    m_n = n;
    if (load) m_shadow = value;
    check("an", 32'(an), 32'(e[11:8]));
    check("seg", 32'(seg), 32'(e[7:1]));
    check("dp", 32'(dp), 32'(e[0]));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic load_word(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    cycle();
    load  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 1'b0, 4'b0000, 0, 4'b1110, 7'b0011001, 1'b1};
    vecs[1]  = '{16'h1234, 1'b0, 4'b0000, 3, 4'b0111, 7'b1111001, 1'b1};
    vecs[2]  = '{16'h00A0, 1'b1, 4'b0000, 0, 4'b1110, 7'b1000000, 1'b1};
    vecs[3]  = '{16'h00A0, 1'b1, 4'b0000, 1, 4'b1101, 7'b0001000, 1'b1};
    vecs[4]  = '{16'h00A0, 1'b1, 4'b0000, 2, 4'b1111, 7'b1111111, 1'b1};
    vecs[5]  = '{16'h00A0, 1'b1, 4'b0000, 3, 4'b1111, 7'b1111111, 1'b1};
    vecs[6]  = '{16'h0000, 1'b1, 4'b0000, 0, 4'b1110, 7'b1000000, 1'b1};
    vecs[7]  = '{16'h0000, 1'b1, 4'b0000, 1, 4'b1111, 7'b1111111, 1'b1};
    vecs[8]  = '{16'hFFFF, 1'b0, 4'b0000, 2, 4'b1011, 7'b0001110, 1'b1};
    vecs[9]  = '{16'h0C00, 1'b1, 4'b0100, 2, 4'b1011, 7'b1000110, 1'b0};
    vecs[10] = '{16'h0C00, 1'b1, 4'b0100, 3, 4'b1111, 7'b1111111, 1'b1};
    vecs[11] = '{16'h0000, 1'b0, 4'b0000, 2, 4'b1011, 7'b1000000, 1'b1};

    reset = 1'b1; value = '0; load = 1'b0; blank_lz = 1'b0; dp_en = '0;
    m_n = 0; m_shadow = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_ft", 32'(frame_tick), 32'h0);
    reset = 1'b0;

    // First edge after release drives digit 0 of the zero shadow.
    cycle();
    check("first_an", 32'(an), 32'hE);
    check("first_seg", 32'(seg), 32'(7'b1000000));

    // Plain scan of 1234 over two frames.
    load_word(16'h1234);
    repeat (2 * FRAME) cycle();

    foreach (vecs[i]) begin
      int k;
      value = vecs[i].value; blank_lz = vecs[i].blz; dp_en = vecs[i].dpe;
      load_word(vecs[i].value);
      k = 0;
      do begin
        cycle();
        k++;
      end while (digit_of(m_n) != vecs[i].digit && k < 2 * FRAME);
      check($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].exp_an));
      check($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].exp_seg));
      check($sformatf("vec%0d_dp", i), 32'(dp), 32'(vecs[i].exp_dp));
    end

    // Without load the display ignores value changes.
    blank_lz = 1'b0; dp_en = '0;
    load_word(16'h1234);
    value = 16'hFFFF;
    repeat (FRAME) cycle();
    check("hold_shadow_seg", 32'(seg), 32'(hex_tbl[4'((m_shadow >> (4 * digit_of(m_n))) & 16'hF)]));
    load_word(16'hFFFF);
    repeat (FRAME) cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      value    = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      load     = ($urandom_range(0, 7) == 0);
      blank_lz = 1'($urandom_range(0, 1));
      dp_en    = 4'($urandom_range(0, 15));
      cycle();
    end
    load = 1'b0;

    // Async reset in the middle of digit 2's slot.
    load_word(16'hBEEF);
    begin
      int k;
      k = 0;
      while (!(digit_of(m_n) == 2 && ((m_n - 1) % DIV) == 1) && k < 2 * FRAME) begin
        cycle();
        k++;
      end
      check("reach_slot2", 32'(digit_of(m_n)), 32'd2);
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_dp", 32'(dp), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_n = 0; m_shadow = '0; value = 16'h5678; blank_lz = 1'b0; dp_en = '0;
    cycle();
    check("post_rst_an", 32'(an), 32'hE);
    check("post_rst_seg", 32'(seg), 32'(7'b1000000));

    // Frame tick spacing over three frames.
    begin
      int last_tick;
      int ticks;
      last_tick = -1;
      ticks = 0;
      for (int k = 0; k < 5 * FRAME && ticks < 4; k++) begin
        cycle();
        if (frame_tick) begin
          check("tick_an", 32'(an), 32'hE);
          if (last_tick >= 0) check("tick_period", 32'(m_n - last_tick), 32'(FRAME));
          last_tick = m_n;
          ticks++;
        end
      end
      check("tick_count", 32'(ticks), 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
